// File: rtl/cache_refill_ctrl.sv
// Miss/refill and write-through controller sitting directly behind the L1 data cache.
// Optional `CACHE_PERF_CNT_EN adds perf_hits / perf_misses event counters.
module cache_refill_ctrl #(
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_read,
   input  logic              cpu_write,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   input  logic              cache_hit,
   input  logic              cache_miss,
   input  logic [DATA_W-1:0] cache_rdata,
   output logic              cpu_stall,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_rvalid,
   output logic              cpu_err,
   output logic              fill_en,
   output logic [ADDR_W-1:0] fill_addr,
   output logic [DATA_W-1:0] fill_data,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
`ifdef CACHE_PERF_CNT_EN
   output logic [31:0]       perf_hits,
   output logic [31:0]       perf_misses,
`endif
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_RD_REQ = 3'd1;
   localparam logic [2:0] S_FILL   = 3'd2;
   localparam logic [2:0] S_WR_REQ = 3'd3;
   localparam logic [2:0] S_RESP   = 3'd4;

   localparam bit         TMO_EN   = (TIMEOUT_CYCLES != 0);
   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

   logic [2:0]        state_q, state_d;
   logic              mem_req_q, mem_req_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              err_q, err_d;
   logic [7:0]        tmo_cnt_q, tmo_cnt_d;

   logic              in_idle;
   logic              hit_take;
   logic              tmo_expired;
   logic [ADDR_W-1:0] addr_aligned;

   // Low address bits are dropped by word alignment; the cache itself qualifies reads.
   logic unused_inputs;
   assign unused_inputs = ^{cpu_read, cpu_addr[1:0]};

   assign in_idle      = (state_q == S_IDLE);
   // A simultaneous hit and miss is illegal and resolves as a miss.
   assign hit_take     = in_idle & cache_hit & ~cache_miss;
   assign tmo_expired  = TMO_EN && (tmo_cnt_q == TMO_LAST);
   assign addr_aligned = {cpu_addr[ADDR_W-1:2], 2'b00};

   always_comb begin
      // NOTE: every next-state signal gets a default here so no path leaves one unassigned (no latches).
      state_d     = state_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      rdata_d     = rdata_q;
      err_d       = 1'b0;
      tmo_cnt_d   = tmo_cnt_q;

      case (state_q)
         S_IDLE: begin
            tmo_cnt_d = '0;
            if (cache_miss) begin
               state_d    = S_RD_REQ;
               mem_req_d  = 1'b1;
               mem_we_d   = 1'b0;
               mem_addr_d = addr_aligned;
            end else if (cpu_write) begin
               state_d     = S_WR_REQ;
               mem_req_d   = 1'b1;
               mem_we_d    = 1'b1;
               mem_addr_d  = addr_aligned;
               mem_wdata_d = cpu_wdata;
            end
         end
         S_RD_REQ: begin
            if (mem_ack) begin
               state_d   = S_FILL;
               mem_req_d = 1'b0;
               rdata_d   = mem_rdata;
            end else if (tmo_expired) begin
               state_d   = S_RESP;
               mem_req_d = 1'b0;
               rdata_d   = '0;
               err_d     = 1'b1;
            end else begin
               tmo_cnt_d = tmo_cnt_q + 8'd1;
            end
         end
         S_WR_REQ: begin
            if (mem_ack) begin
               state_d   = S_IDLE;
               mem_req_d = 1'b0;
            end else if (tmo_expired) begin
               state_d   = S_IDLE;
               mem_req_d = 1'b0;
               err_d     = 1'b1;
            end else begin
               tmo_cnt_d = tmo_cnt_q + 8'd1;
            end
         end
         S_FILL: state_d = S_RESP;
         S_RESP: state_d = S_IDLE;
         default: begin
            state_d   = S_IDLE;
            mem_req_d = 1'b0;
         end
      endcase
   end

   // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         rdata_q     <= '0;
         err_q       <= 1'b0;
         tmo_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         rdata_q     <= rdata_d;
         err_q       <= err_d;
         tmo_cnt_q   <= tmo_cnt_d;
      end
   end

   always_comb begin
      cpu_rvalid = 1'b0;
      cpu_rdata  = '0;
      if (state_q == S_RESP) begin
         cpu_rvalid = 1'b1;
         cpu_rdata  = rdata_q;
      end else if (hit_take) begin
         cpu_rvalid = 1'b1;
         cpu_rdata  = cache_rdata;
      end
   end

   assign cpu_stall = ~in_idle | cache_miss | (in_idle & cpu_write);
   assign cpu_err   = err_q;
   assign fill_en   = (state_q == S_FILL);
   assign fill_addr = mem_addr_q;
   assign fill_data = rdata_q;
   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;

`ifdef CACHE_PERF_CNT_EN
   logic [31:0] perf_hits_q, perf_misses_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         perf_hits_q   <= '0;
         perf_misses_q <= '0;
      end else begin
         if (hit_take)              perf_hits_q   <= perf_hits_q + 32'd1;
         if (in_idle && cache_miss) perf_misses_q <= perf_misses_q + 32'd1;
      end
   end

   assign perf_hits   = perf_hits_q;
   assign perf_misses = perf_misses_q;
`endif

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Scoreboard bench for cache_refill_ctrl: drivers queue expected events with their cycle,
// a negedge monitor pops and compares whenever the DUT presents mem_req/fill_en/cpu_rvalid/cpu_err.
module tb_cache_refill_ctrl;

   localparam int TO = 4;

   typedef enum int {EV_MEM, EV_FILL, EV_RD, EV_WERR} ev_kind_t;
   typedef struct {
      ev_kind_t    kind;
      int          cyc;
      logic [31:0] addr;
      logic [31:0] data;
      logic        we;
      logic        err;
   } ev_t;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        cpu_read = 1'b0;
   logic        cpu_write = 1'b0;
   logic [31:0] cpu_addr = '0;
   logic [31:0] cpu_wdata = '0;
   logic        cache_hit = 1'b0;
   logic        cache_miss = 1'b0;
   logic [31:0] cache_rdata = '0;
   logic        mem_ack = 1'b0;
   logic [31:0] mem_rdata = '0;
   logic        cpu_stall, cpu_rvalid, cpu_err, fill_en, mem_req, mem_we;
   logic [31:0] cpu_rdata, fill_addr, fill_data, mem_addr, mem_wdata;
`ifdef CACHE_PERF_CNT_EN
   logic [31:0] perf_hits, perf_misses;
`endif

   int  n_checks = 0;
   int  n_errors = 0;
   int  cyc = 0;
   logic prev_req = 1'b0;
   ev_t sb[$];

   cache_refill_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .reset(reset),
      .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cache_hit(cache_hit), .cache_miss(cache_miss), .cache_rdata(cache_rdata),
      .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid), .cpu_err(cpu_err),
      .fill_en(fill_en), .fill_addr(fill_addr), .fill_data(fill_data),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
`ifdef CACHE_PERF_CNT_EN
      .perf_hits(perf_hits), .perf_misses(perf_misses),
`endif
      .mem_ack(mem_ack), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
      end
   endtask

   function automatic void push(input ev_kind_t k, input int c, input logic [31:0] a,
                                input logic [31:0] d, input logic we, input logic err);
      ev_t e;
      e.kind = k; e.cyc = c; e.addr = a; e.data = d; e.we = we; e.err = err;
      sb.push_back(e);
   endfunction

   task automatic mon_evt(input ev_kind_t k);
      ev_t e;
      check("event_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
         e = sb.pop_front();
         check("event_kind", 32'(k), 32'(e.kind));
         check("event_cycle", 32'(cyc), 32'(e.cyc));
         case (k)
            EV_MEM: begin
               check("mem_addr", mem_addr, e.addr);
               check("mem_we", 32'(mem_we), 32'(e.we));
               if (e.we) check("mem_wdata", mem_wdata, e.data);
            end
            EV_FILL: begin
               check("fill_addr", fill_addr, e.addr);
               check("fill_data", fill_data, e.data);
            end
            EV_RD: begin
               check("cpu_rdata", cpu_rdata, e.data);
               check("cpu_err_with_rvalid", 32'(cpu_err), 32'(e.err));
            end
            default: ;
         endcase
      end
   endtask

   // Monitor: decoupled from the drivers, reacts only to what the DUT presents.
   always @(negedge clk) begin
      if (!reset) begin
         if (mem_req && !prev_req) mon_evt(EV_MEM);
         if (fill_en)              mon_evt(EV_FILL);
         if (cpu_rvalid)           mon_evt(EV_RD);
         else if (cpu_err)         mon_evt(EV_WERR);
      end
      prev_req <= mem_req;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_hit(input logic [31:0] data);
      tick();
      cache_hit   = 1'b1;
      cache_rdata = data;
      push(EV_RD, cyc, '0, data, 1'b0, 1'b0);
      #1;
      check("hit_stall", 32'(cpu_stall), 32'd0);
      check("hit_mem_req", 32'(mem_req), 32'd0);
      tick();
      cache_hit   = 1'b0;
      cache_rdata = '0;
   endtask

   // Read miss; ack arrives after n_wait idle request cycles, or never (timeout).
   task automatic rd_miss(input logic [31:0] addr, input logic [31:0] rdata,
                          input int n_wait, input bit ack, input bit both);
      int          t0, len, reqlast;
      logic [31:0] wa;
      wa = {addr[31:2], 2'b00};
      tick();
      t0 = cyc;
      cpu_addr = addr;
      push(EV_MEM, t0 + 1, wa, '0, 1'b0, 1'b0);
      if (ack) begin
         reqlast = n_wait + 1;
         len     = n_wait + 3;
         push(EV_FILL, t0 + n_wait + 2, wa, rdata, 1'b0, 1'b0);
         push(EV_RD, t0 + n_wait + 3, '0, rdata, 1'b0, 1'b0);
      end else begin
         reqlast = TO;
         len     = TO + 1;
         push(EV_RD, t0 + TO + 1, '0, 32'h0, 1'b0, 1'b1);
      end
      for (int k = 0; k <= len + 1; k++) begin
         if (k > 0) tick();
         cache_miss  = (k == 0);
         cache_hit   = both && (k == 0);
         cache_rdata = (both && k == 0) ? 32'h0BAD_0BAD : 32'h0;
         mem_ack     = ack && (k == reqlast);
         mem_rdata   = mem_ack ? rdata : 32'h0;
         #1;
         check("rd_stall", 32'(cpu_stall), 32'(k <= len));
         check("rd_mem_req", 32'(mem_req), 32'(k >= 1 && k <= reqlast));
      end
   endtask

   task automatic wr(input logic [31:0] addr, input logic [31:0] wdata,
                     input int n_wait, input bit ack);
      int t0, len, reqlast;
      tick();
      t0 = cyc;
      cpu_addr  = addr;
      cpu_wdata = wdata;
      push(EV_MEM, t0 + 1, {addr[31:2], 2'b00}, wdata, 1'b1, 1'b0);
      if (ack) begin
         reqlast = n_wait + 1;
         len     = n_wait + 1;
      end else begin
         reqlast = TO;
         len     = TO;
         push(EV_WERR, t0 + TO + 1, '0, '0, 1'b0, 1'b1);
      end
      for (int k = 0; k <= len + 1; k++) begin
         if (k > 0) tick();
         cpu_write = (k <= len);
         mem_ack   = ack && (k == reqlast);
         #1;
         check("wr_stall", 32'(cpu_stall), 32'(k <= len));
         check("wr_mem_req", 32'(mem_req), 32'(k >= 1 && k <= reqlast));
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0;
      #1 reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_mem_req", 32'(mem_req), 32'd0);
      check("rst_fill_en", 32'(fill_en), 32'd0);
      check("rst_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
      check("rst_cpu_err", 32'(cpu_err), 32'd0);
      check("rst_cpu_rdata", cpu_rdata, 32'd0);
      check("rst_mem_addr", mem_addr, 32'd0);
      check("rst_mem_wdata", mem_wdata, 32'd0);
      check("rst_mem_we", 32'(mem_we), 32'd0);
      check("rst_cpu_stall", 32'(cpu_stall), 32'd0);
      tick();
      reset = 1'b0;

      do_hit(32'hDEAD_BEEF);
      do_hit(32'h1234_5678);
      rd_miss(32'h0000_1236, 32'hCAFE_F00D, 3, 1'b1, 1'b0);  // ack on the timeout-expiry cycle
      rd_miss(32'h0000_2001, 32'h1111_2222, 0, 1'b1, 1'b1);  // hit+miss together, minimum latency
      wr(32'h0000_0040, 32'h0000_0055, 1, 1'b1);
      rd_miss(32'h0000_0500, 32'h0, 0, 1'b0, 1'b0);          // read timeout
      wr(32'h0000_0044, 32'h0000_0066, 0, 1'b0);             // write timeout

      // Miss and store together: refill first, store taken on return to IDLE.
      tick();
      t0 = cyc;
      cpu_addr  = 32'h0000_0080;
      cpu_wdata = 32'h0000_0077;
      push(EV_MEM, t0 + 1, 32'h80, '0, 1'b0, 1'b0);
      push(EV_FILL, t0 + 2, 32'h80, 32'hA1B2_C3D4, 1'b0, 1'b0);
      push(EV_RD, t0 + 3, '0, 32'hA1B2_C3D4, 1'b0, 1'b0);
      push(EV_MEM, t0 + 5, 32'h80, 32'h77, 1'b1, 1'b0);
      for (int k = 0; k <= 6; k++) begin
         if (k > 0) tick();
         cache_miss = (k == 0);
         cpu_write  = (k <= 4);
         mem_ack    = (k == 1) || (k == 5);
         mem_rdata  = (k == 1) ? 32'hA1B2_C3D4 : 32'h0;
         #1;
         check("combo_stall", 32'(cpu_stall), 32'(k <= 5));
         check("combo_mem_req", 32'(mem_req), 32'(k == 1 || k == 5));
      end

      // Reset while in RD_REQ; the late ack must be ignored.
      tick();
      t0 = cyc;
      cpu_addr   = 32'h0000_0200;
      cache_miss = 1'b1;
      push(EV_MEM, t0 + 1, 32'h200, '0, 1'b0, 1'b0);
      tick();
      cache_miss = 1'b0;
      tick();
      #1 reset = 1'b1;
      #1;
      check("rst_mid_mem_req", 32'(mem_req), 32'd0);
      check("rst_mid_stall", 32'(cpu_stall), 32'd0);
      tick();
      reset     = 1'b0;
      mem_ack   = 1'b1;
      mem_rdata = 32'hFFFF_FFFF;
      #1;
      check("late_ack_mem_req", 32'(mem_req), 32'd0);
      check("late_ack_stall", 32'(cpu_stall), 32'd0);
      tick();
      mem_ack   = 1'b0;
      mem_rdata = '0;
      #1;
      check("late_ack_fill_en", 32'(fill_en), 32'd0);
      check("late_ack_rvalid", 32'(cpu_rvalid), 32'd0);

      rd_miss(32'h0000_0300, 32'hA5A5_A5A5, 1, 1'b1, 1'b0);

      repeat (5) tick();
      check("scoreboard_drained", 32'(sb.size()), 32'd0);
`ifdef CACHE_PERF_CNT_EN
      check("perf_hits", perf_hits, 32'd0);
      check("perf_misses", perf_misses, 32'd1);
`endif
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
